div_unit: RTL and testbench

Iterative 32-bit signed/unsigned divider for the execute stage. It accepts a divide request with two operands and runs a fixed-latency radix-2 restoring division. It reports progress on `div_start` (busy) and `div_end` (result valid), and returns the remainder on `div_hi_data` and the quotient on `div_lo_data`. It produces the divide-side inputs that the execute-stage HI/LO select logic uses for stall status and HI/LO write data.

---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
package div_unit_pkg;

  localparam int DATALENGTH = 32;
  localparam int DIV_CYCLES = 32;
  localparam logic [DATALENGTH-1:0] ZEROWORD = '0;

  // State encoding: IDLE=00, BUSY=01, DONE=10
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // Two's-complement magnitude of a signed word; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DATALENGTH-1:0] mag(input logic [DATALENGTH-1:0] v);
    return v[DATALENGTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/status bundle between the execute stage and the divider.
interface div_unit_if;
  import div_unit_pkg::*;

  logic                  div_req;
  logic                  div_signed;
  logic [DATALENGTH-1:0] div_opa;
  logic [DATALENGTH-1:0] div_opb;
  logic                  div_ack;
  logic                  div_flush;
  logic                  div_start;
  logic                  div_end;
  logic [DATALENGTH-1:0] div_hi_data;
  logic [DATALENGTH-1:0] div_lo_data;

  // Execute stage drives the request and consumes status/results
  modport master (
    output div_req, div_signed, div_opa, div_opb, div_ack, div_flush,
    input  div_start, div_end, div_hi_data, div_lo_data
  );

  // Divider consumes the request and produces status/results
  modport slave (
    input  div_req, div_signed, div_opa, div_opb, div_ack, div_flush,
    output div_start, div_end, div_hi_data, div_lo_data
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider, 32 iterations, with signed fixup and
// divide-by-zero override. Remainder on hi, quotient on lo.
module div_unit
  import div_unit_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  div_unit_if.slave bus
);

  localparam logic [5:0] CNT_LAST = 6'(DIV_CYCLES - 1);

  div_state_e            state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [DATALENGTH-1:0] rem_q, rem_d;
  logic [DATALENGTH-1:0] quo_q, quo_d;
  logic [DATALENGTH-1:0] divisor_q, divisor_d;
  logic [DATALENGTH-1:0] dividend_q, dividend_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  div_zero_q, div_zero_d;
  logic [DATALENGTH-1:0] hi_q, hi_d;
  logic [DATALENGTH-1:0] lo_q, lo_d;
  logic                  start_q, start_d;
  logic                  end_q, end_d;

  // One restoring step: {rem, quo} shifted left, then trial subtract.
  logic [DATALENGTH:0]   rem_shift;
  logic [DATALENGTH:0]   trial;
  logic [DATALENGTH-1:0] step_rem;
  logic [DATALENGTH-1:0] step_quo;

  // Datapath step, result fixup and next-state selection
  always_comb begin
    rem_shift = {rem_q, quo_q[DATALENGTH-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    step_rem  = trial[DATALENGTH] ? rem_shift[DATALENGTH-1:0] : trial[DATALENGTH-1:0];
    step_quo  = {quo_q[DATALENGTH-2:0], ~trial[DATALENGTH]};

    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.div_req) begin
          // Dividend magnitude is loaded into the quotient register and
          // shifted out into rem one bit per step.
          quo_d      = bus.div_signed ? mag(bus.div_opa) : bus.div_opa;
          divisor_d  = bus.div_signed ? mag(bus.div_opb) : bus.div_opb;
          dividend_d = bus.div_opa;
          neg_quo_d  = bus.div_signed & (bus.div_opa[DATALENGTH-1] ^ bus.div_opb[DATALENGTH-1]);
          neg_rem_d  = bus.div_signed & bus.div_opa[DATALENGTH-1];
          div_zero_d = (bus.div_opb == ZEROWORD);
          rem_d      = ZEROWORD;
          cnt_d      = '0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          if (div_zero_q) begin
            // Zero divisor returns all-ones quotient and the raw dividend
            lo_d = '1;
            hi_d = dividend_q;
          end else begin
            lo_d = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
            hi_d = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
          end
        end
      end
      ST_DONE: begin
        if (bus.div_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush cancels everything; any result computed this cycle is dropped
    if (bus.div_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    start_d = (state_d == ST_BUSY);
    end_d   = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= ZEROWORD;
      quo_q      <= ZEROWORD;
      divisor_q  <= ZEROWORD;
      dividend_q <= ZEROWORD;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= ZEROWORD;
      lo_q       <= ZEROWORD;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      start_q    <= start_d;
      end_q      <= end_d;
    end
  end

  assign bus.div_start   = start_q;
  assign bus.div_end     = end_q;
  assign bus.div_hi_data = hi_q;
  assign bus.div_lo_data = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: stimulus pushes expected {hi,lo} into a
// queue, a negedge monitor pops on each new div_end and checks it.
module tb_div_unit;

  logic clk;
  logic rst;

  div_unit_if bus ();

  div_unit dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0] exp_q[$];
  logic [63:0] cur_exp;
  logic        have_cur = 1'b0;
  logic        prev_end = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: status exclusivity every cycle, result checks while div_end
  always @(negedge clk) begin
    if (!rst) begin
      check("start_end_exclusive", {63'd0, bus.div_start & bus.div_end}, 64'd0);
      if (bus.div_end && !prev_end) begin
        if (exp_q.size() == 0) begin
          check("unexpected_div_end", 64'd1, 64'd0);
          have_cur = 1'b0;
        end else begin
          cur_exp  = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (bus.div_end && have_cur)
        check("result_hi_lo", {bus.div_hi_data, bus.div_lo_data}, cur_exp);
    end
    prev_end = bus.div_end;
  end

  // Issue one divide, count busy cycles, hold the result, then ack it
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input int hold);
    int n;
    exp_q.push_back({exp_hi, exp_lo});
    $display("div sgn=%0d a=%h b=%h expect lo=%h hi=%h", sgn, a, b, exp_lo, exp_hi);
    bus.div_signed = sgn;
    bus.div_opa    = a;
    bus.div_opb    = b;
    bus.div_req    = 1'b1;
    @(posedge clk); #1;
    bus.div_req = 1'b0;
    n = 0;
    while (bus.div_start && n < 40) begin
      // Operands wander while busy; they must not matter
      bus.div_opa    = $urandom;
      bus.div_opb    = $urandom;
      bus.div_signed = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    check("busy_cycles", 64'(n), 64'd32);
    check("done_after_busy", {63'd0, bus.div_end}, 64'd1);
    repeat (hold) @(posedge clk);
    #1;
    check("held_before_ack", {63'd0, bus.div_end}, 64'd1);
    bus.div_ack = 1'b1;
    @(posedge clk); #1;
    bus.div_ack = 1'b0;
    check("idle_after_ack", {62'd0, bus.div_start, bus.div_end}, 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.div_req    = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_opa    = '0;
    bus.div_opb    = '0;
    bus.div_ack    = 1'b0;
    bus.div_flush  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", {62'd0, bus.div_start, bus.div_end}, 64'd0);
    check("reset_data", {bus.div_hi_data, bus.div_lo_data}, 64'd0);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 5);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1);
    run_div(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 2);
    run_div(1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 0);

    // Flush at BUSY cycle 10
    $display("flush during busy");
    bus.div_signed = 1'b0;
    bus.div_opa    = 32'd1000;
    bus.div_opb    = 32'd3;
    bus.div_req    = 1'b1;
    @(posedge clk); #1;
    bus.div_req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.div_flush = 1'b1;
    @(posedge clk); #1;
    bus.div_flush = 1'b0;
    check("flush_drops_start", {63'd0, bus.div_start}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_end", {63'd0, bus.div_end}, 64'd0);
    check("flush_keeps_last", {bus.div_hi_data, bus.div_lo_data}, {32'hFFFFFFF9, 32'hFFFFFFFF});
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 0);

    // Reset at BUSY cycle 20
    $display("reset during busy");
    bus.div_signed = 1'b1;
    bus.div_opa    = 32'd1000;
    bus.div_opb    = 32'd3;
    bus.div_req    = 1'b1;
    @(posedge clk); #1;
    bus.div_req = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_reset_outputs",
          {bus.div_hi_data[30:0], bus.div_lo_data, bus.div_start},
          64'd0);
    check("mid_reset_end_hi31", {62'd0, bus.div_end, bus.div_hi_data[31]}, 64'd0);
    run_div(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 2);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
